data_sram_arb: RTL and testbench
================================

DATA_SRAM_ARB -- requirements
Module: data_sram_arb

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: the maximum number of consecutive cycles data may win while inst is waiting.
REQ-002 Port clk, input, 1: the single clock; all state updates on posedge clk.
REQ-003 Port rst, input, 1: reset, asynchronous and active-high.
REQ-004 Port inst_req, input, 1: fetch requester asserts a read request.
REQ-005 Port inst_addr, input, 32: fetch read address (word-aligned).
REQ-006 Port inst_addr_ok, output, 1: fetch request granted this cycle.
REQ-007 Port inst_data_ok, output, 1: fetch read data valid this cycle.
REQ-008 Port inst_rdata, output, 32: fetch read data.
REQ-009 Port data_req, input, 1: load/store requester asserts a request.
REQ-010 Port data_wr, input, 1: 1 = store, 0 = load.
REQ-011 Port data_wstrb, input, 4: store byte enables.
REQ-012 Port data_addr, input, 32: load/store address.
REQ-013 Port data_wdata, input, 32: store data.
REQ-014 Port data_addr_ok, output, 1: data request granted this cycle.
REQ-015 Port data_data_ok, output, 1: data access complete this cycle.
REQ-016 Port data_rdata, output, 32: load data, full word, unextracted.
REQ-017 Port sram_en, output, 1: single-port synchronous SRAM enable.
REQ-018 Port sram_wen, output, 4: SRAM byte write enables.
REQ-019 Port sram_addr, output, 32: SRAM address.
REQ-020 Port sram_wdata, output, 32: SRAM write data.
REQ-021 Port sram_rdata, input, 32: SRAM read data, valid exactly one cycle after an enabled read.
REQ-022 Port stallreq, output, 1: pipeline stall request.

Function
REQ-023 At most one grant is made per cycle; a grant pulses the winner's addr_ok and drives sram_en=1 with that requester's address in the same cycle (combinational).
REQ-024 The arbiter is pipelined: a new grant may issue in the same cycle as the data_ok of the previous grant.
REQ-025 With a single requester active, that requester is granted immediately.
REQ-026 When inst_req and data_req are both high, data wins unless starve_cnt == STARVE_LIMIT, in which case inst wins.
REQ-027 starve_cnt behaviour:
- Width is clog2(STARVE_LIMIT+1).
- Increments, saturating at STARVE_LIMIT, on each data grant while inst_req=1.
- Clears on any inst grant, or whenever inst_req=0.
REQ-028 For an inst grant, sram_wen=4'b0000.
REQ-029 For a data grant: sram_wen = data_wr ? data_wstrb : 4'b0000, and sram_wdata = data_wdata; sram_wdata=0 when not a data store.
REQ-030 When no grant is made, sram_en=0, sram_wen=0 and sram_addr=0.
REQ-031 The register resp_owner (NONE/INST/DATA) is loaded with the grant winner each cycle, or with NONE if no grant is made.
REQ-032 In the cycle after a grant, the owner's data_ok pulses for exactly one cycle.
REQ-033 inst_rdata and data_rdata equal sram_rdata while the owner's data_ok is high, and 0 otherwise.
REQ-034 A store also returns data_data_ok one cycle after its grant, with data_rdata=0.
REQ-035 stallreq = (inst_req & ~inst_addr_ok) | (data_req & ~data_addr_ok) | (resp_owner==DATA & ~data_wr_q), where data_wr_q is the registered data_wr of the granted data access. This holds the pipeline for the load-return cycle.
REQ-036 Requesters hold req and payload stable until addr_ok; behaviour with a payload that changes before grant is undefined.

Reset
REQ-037 While rst=1, all of the following are 0: addr_ok, data_ok, rdata, sram_en, sram_wen, sram_addr, sram_wdata and stallreq.
REQ-038 While rst=1, resp_owner=NONE and starve_cnt=0.
REQ-039 Asserting rst mid-access discards the outstanding response; no data_ok is produced after rst deasserts for an access granted before reset.
REQ-040 The first grant is possible in the first posedge-bounded cycle with rst=0.

Verification
REQ-041 inst_req=1 alone, inst_addr=0x100, sram_rdata=0xDEADBEEF next cycle -> inst_addr_ok=1 and sram_en=1 in cycle N; inst_data_ok=1 and inst_rdata=0xDEADBEEF in cycle N+1.
REQ-042 inst_req and data_req both held high with a continuous data load stream, STARVE_LIMIT=4 -> 4 data grants, then 1 inst grant, then starve_cnt=0.
REQ-043 data store at addr 0x200, wstrb=4'b0011, wdata=0x1234 -> sram_wen=4'b0011 and sram_wdata=0x1234 in the grant cycle; data_data_ok=1 and data_rdata=0 in the next cycle.
REQ-044 Back-to-back data loads to 0x10 and 0x14 -> grants in cycles N and N+1; data_data_ok in N+1 and N+2 with matching sram_rdata.
REQ-045 rst asserted asynchronously in the cycle after a grant -> data_ok never pulses for that access, and all outputs read 0 immediately.
REQ-046 Load granted in cycle N -> stallreq=1 in cycle N+1 and stallreq=0 in N+2 with no new request pending.

Source files
------------

// File: rtl/data_sram_arb.sv
// Two-requester arbiter sharing one single-port synchronous SRAM between instruction fetch and
// load/store. Data has priority; a saturating counter bounds how long a waiting fetch is starved.
`timescale 1ns/1ps
module data_sram_arb #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic        stallreq
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_INST = 2'd1;
  localparam logic [1:0] OWN_DATA = 2'd2;

  logic [CntW-1:0] starve_cnt;
  logic [1:0]      resp_owner;
  logic            data_wr_q;
  logic            inst_win;
  logic            data_win;

  // Grants are gated by rst so every output reads 0 while reset is held.
  always_comb begin
    inst_win = ~rst & inst_req & (~data_req | (starve_cnt == CntMax));
    data_win = ~rst & data_req & ~inst_win;
  end

  always_comb begin
    inst_addr_ok = inst_win;
    data_addr_ok = data_win;
    sram_en      = inst_win | data_win;
    sram_addr    = inst_win ? inst_addr : (data_win ? data_addr : 32'h0);
    sram_wen     = (data_win & data_wr) ? data_wstrb : 4'b0000;
    sram_wdata   = (data_win & data_wr) ? data_wdata : 32'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      resp_owner <= OWN_NONE;
      data_wr_q  <= 1'b0;
    end else begin
      if (!inst_req || inst_win) begin
        starve_cnt <= '0;
      end else if (data_win && (starve_cnt != CntMax)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
      resp_owner <= inst_win ? OWN_INST : (data_win ? OWN_DATA : OWN_NONE);
      data_wr_q  <= data_win & data_wr;
    end
  end

  // A store completes with data_ok but never forwards SRAM read data.
  always_comb begin
    inst_data_ok = (resp_owner == OWN_INST);
    data_data_ok = (resp_owner == OWN_DATA);
    inst_rdata   = inst_data_ok ? sram_rdata : 32'h0;
    data_rdata   = (data_data_ok & ~data_wr_q) ? sram_rdata : 32'h0;
    stallreq     = ~rst & ((inst_req & ~inst_win) | (data_req & ~data_win) |
                           (data_data_ok & ~data_wr_q));
  end

endmodule

// File: tb/tb_data_sram_arb.sv
// Bench for data_sram_arb: directed scenarios, then random traffic against a memory-backed model.
`timescale 1ns/1ps
module tb_data_sram_arb;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        stallreq;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:15];

  data_sram_arb #(.STARVE_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .sram_en      (sram_en),
    .sram_wen     (sram_wen),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .stallreq     (stallreq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_iaok"}, {31'h0, inst_addr_ok}, 32'h0);
    chk({tag, "_daok"}, {31'h0, data_addr_ok}, 32'h0);
    chk({tag, "_idok"}, {31'h0, inst_data_ok}, 32'h0);
    chk({tag, "_ddok"}, {31'h0, data_data_ok}, 32'h0);
    chk({tag, "_irdata"}, inst_rdata, 32'h0);
    chk({tag, "_drdata"}, data_rdata, 32'h0);
    chk({tag, "_en"}, {31'h0, sram_en}, 32'h0);
    chk({tag, "_wen"}, {28'h0, sram_wen}, 32'h0);
    chk({tag, "_addr"}, sram_addr, 32'h0);
    chk({tag, "_wdata"}, sram_wdata, 32'h0);
    chk({tag, "_stall"}, {31'h0, stallreq}, 32'h0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int waits;
    int pend;
    logic pend_wr;
    logic [31:0] pend_val;
    logic ei, ed, g_wr;
    logic [3:0] g_strb, wi;
    logic [31:0] g_wdata, g_iaddr, g_daddr, exp_v;

    for (int i = 0; i < 16; i++) mem[i] = $urandom;

    // Reset with every requester active: outputs must stay quiet.
    rst = 1'b1;
    inst_req = 1'b1; inst_addr = 32'h44; data_req = 1'b1; data_wr = 1'b1;
    data_wstrb = 4'hf; data_addr = 32'h88; data_wdata = 32'h5555_aaaa; sram_rdata = 32'hffff_ffff;
    @(negedge clk);
    all_zero("reset");
    next_cycle();
    inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;
    inst_addr = 32'h0; data_addr = 32'h0; data_wdata = 32'h0;
    next_cycle();
    rst = 1'b0;

    // Single fetch: grant now, data next cycle.
    inst_req = 1'b1; inst_addr = 32'h100;
    @(negedge clk);
    chk("f_iaok", {31'h0, inst_addr_ok}, 32'h1);
    chk("f_en", {31'h0, sram_en}, 32'h1);
    chk("f_addr", sram_addr, 32'h100);
    chk("f_wen", {28'h0, sram_wen}, 32'h0);
    chk("f_stall", {31'h0, stallreq}, 32'h0);
    next_cycle();
    inst_req = 1'b0; sram_rdata = 32'hdead_beef;
    @(negedge clk);
    chk("f_idok", {31'h0, inst_data_ok}, 32'h1);
    chk("f_irdata", inst_rdata, 32'hdead_beef);
    chk("f_ddok", {31'h0, data_data_ok}, 32'h0);
    chk("f_en_idle", {31'h0, sram_en}, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("f_idok_off", {31'h0, inst_data_ok}, 32'h0);
    chk("f_irdata_off", inst_rdata, 32'h0);

    // Store: byte enables and data in grant cycle, zero read data on completion.
    next_cycle();
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011; data_addr = 32'h200;
    data_wdata = 32'h1234;
    @(negedge clk);
    chk("st_daok", {31'h0, data_addr_ok}, 32'h1);
    chk("st_wen", {28'h0, sram_wen}, 32'h3);
    chk("st_wdata", sram_wdata, 32'h1234);
    chk("st_addr", sram_addr, 32'h200);
    next_cycle();
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0; data_wdata = 32'h0;
    sram_rdata = 32'hffff_ffff;
    @(negedge clk);
    chk("st_ddok", {31'h0, data_data_ok}, 32'h1);
    chk("st_drdata", data_rdata, 32'h0);
    chk("st_stall", {31'h0, stallreq}, 32'h0);

    // Back-to-back loads, with the load-return stall.
    next_cycle();
    data_req = 1'b1; data_addr = 32'h10;
    @(negedge clk);
    chk("ld0_daok", {31'h0, data_addr_ok}, 32'h1);
    chk("ld0_addr", sram_addr, 32'h10);
    chk("ld0_wdata", sram_wdata, 32'h0);
    next_cycle();
    data_addr = 32'h14; sram_rdata = 32'h0a0a_0a0a;
    @(negedge clk);
    chk("ld1_daok", {31'h0, data_addr_ok}, 32'h1);
    chk("ld1_addr", sram_addr, 32'h14);
    chk("ld0_ddok", {31'h0, data_data_ok}, 32'h1);
    chk("ld0_rdata", data_rdata, 32'h0a0a_0a0a);
    chk("ld0_stall", {31'h0, stallreq}, 32'h1);
    next_cycle();
    data_req = 1'b0; sram_rdata = 32'h0b0b_0b0b;
    @(negedge clk);
    chk("ld1_ddok", {31'h0, data_data_ok}, 32'h1);
    chk("ld1_rdata", data_rdata, 32'h0b0b_0b0b);
    chk("ld1_stall", {31'h0, stallreq}, 32'h1);
    next_cycle();
    @(negedge clk);
    chk("ld_idle_ddok", {31'h0, data_data_ok}, 32'h0);
    chk("ld_idle_stall", {31'h0, stallreq}, 32'h0);

    // Starvation: with both requesting, every fifth grant goes to fetch.
    next_cycle();
    inst_req = 1'b1; inst_addr = 32'h300; data_req = 1'b1; data_addr = 32'h20;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("stv%0d_iaok", i), {31'h0, inst_addr_ok}, {31'h0, (i % 5) == 4});
      chk($sformatf("stv%0d_daok", i), {31'h0, data_addr_ok}, {31'h0, (i % 5) != 4});
      chk($sformatf("stv%0d_addr", i), sram_addr, ((i % 5) == 4) ? 32'h300 : 32'h20);
      next_cycle();
    end
    inst_req = 1'b0; data_req = 1'b0;
    next_cycle();

    // Reset in the cycle after a grant kills the outstanding response.
    data_req = 1'b1; data_addr = 32'h24;
    @(negedge clk);
    chk("rs_daok", {31'h0, data_addr_ok}, 32'h1);
    next_cycle();
    data_req = 1'b0; sram_rdata = 32'h7777_7777;
    #1;
    chk("rs_pending", {31'h0, data_data_ok}, 32'h1);
    rst = 1'b1;
    #1;
    all_zero("rs_async");
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rs_after_ddok", {31'h0, data_data_ok}, 32'h0);
    chk("rs_after_drdata", data_rdata, 32'h0);
    chk("rs_after_stall", {31'h0, stallreq}, 32'h0);
    next_cycle();

    // Random traffic against a memory-backed model.
    waits = 0; pend = 0; pend_wr = 1'b0; pend_val = 32'h0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      ei = inst_req && (!data_req || waits == LIMIT);
      ed = data_req && !ei;
      chk("r_iaok", {31'h0, inst_addr_ok}, {31'h0, ei});
      chk("r_daok", {31'h0, data_addr_ok}, {31'h0, ed});
      chk("r_en", {31'h0, sram_en}, {31'h0, ei || ed});
      chk("r_addr", sram_addr, ei ? inst_addr : (ed ? data_addr : 32'h0));
      chk("r_wen", {28'h0, sram_wen}, {28'h0, (ed && data_wr) ? data_wstrb : 4'h0});
      chk("r_wdata", sram_wdata, (ed && data_wr) ? data_wdata : 32'h0);
      chk("r_idok", {31'h0, inst_data_ok}, {31'h0, pend == 1});
      chk("r_ddok", {31'h0, data_data_ok}, {31'h0, pend == 2});
      chk("r_irdata", inst_rdata, (pend == 1) ? pend_val : 32'h0);
      chk("r_drdata", data_rdata, (pend == 2 && !pend_wr) ? pend_val : 32'h0);
      chk("r_stall", {31'h0, stallreq},
          {31'h0, (inst_req && !ei) || (data_req && !ed) || (pend == 2 && !pend_wr)});

      // Fetch has now waited one more data grant, or is no longer waiting.
      if (!inst_req || ei) waits = 0;
      else if (ed && waits < LIMIT) waits++;
      g_wr = data_wr; g_strb = data_wstrb; g_wdata = data_wdata;
      g_iaddr = inst_addr; g_daddr = data_addr;

      next_cycle();
      if (ed && g_wr) begin
        wi = g_daddr[5:2];
        for (int b = 0; b < 4; b++) if (g_strb[b]) mem[wi][b*8 +: 8] = g_wdata[b*8 +: 8];
      end
      if (ei) begin
        wi = g_iaddr[5:2]; exp_v = mem[wi];
      end else if (ed && !g_wr) begin
        wi = g_daddr[5:2]; exp_v = mem[wi];
      end else begin
        exp_v = $urandom;
      end
      sram_rdata = exp_v;
      pend = ei ? 1 : (ed ? 2 : 0);
      pend_wr = ed && g_wr;
      pend_val = exp_v;

      if (ei) inst_req = 1'b0;
      if (ed) data_req = 1'b0;
      if (!inst_req && $urandom_range(0, 9) < 6) begin
        inst_req = 1'b1;
        inst_addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      end
      if (!data_req && $urandom_range(0, 9) < 7) begin
        data_req = 1'b1;
        data_wr = $urandom_range(0, 2) == 0;
        data_wstrb = 4'($urandom);
        data_addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        data_wdata = $urandom;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
